// File: rtl/conv_window_gen.sv
// Streaming 5x5 sliding-window generator: line buffers plus a shifting window register.
// Optional frame counter output enabled by defining CONV_WINDOW_GEN_STATUS_EN.
module conv_window_gen #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int IntSize = 8,
    parameter int K       = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IntSize-1:0]     pix_in,
    input  logic                   pix_valid,
    input  logic                   pix_sof,
    output logic                   pix_ready,
    output logic [K*K*IntSize-1:0] win_out,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   win_last
`ifdef CONV_WINDOW_GEN_STATUS_EN
    ,
    output logic [15:0]            frame_cnt
`endif
);

    localparam int NLB = K - 1;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    genvar gi;

    logic [CW-1:0]      col_reg;
    logic [RW-1:0]      row_reg;
    logic [CW-1:0]      cur_col;
    logic [RW-1:0]      cur_row;
    logic [CW-1:0]      next_col;
    logic               at_end_col;
    logic               at_end_row;
    logic               accept;
    logic               complete;
    logic               win_valid_reg;
    logic               win_last_reg;
    logic [IntSize-1:0] lb_rd   [NLB];
    logic [IntSize-1:0] new_col [K];

    assign pix_ready = !win_valid_reg || win_ready;
    assign win_valid = win_valid_reg;
    assign win_last  = win_last_reg;

    // A start-of-frame pixel overrides the counters and is taken as (0,0).
    always_comb begin
        accept     = pix_valid && pix_ready;
        cur_col    = pix_sof ? '0 : col_reg;
        cur_row    = pix_sof ? '0 : row_reg;
        at_end_col = (cur_col == CW'(IMG_W - 1));
        at_end_row = (cur_row == RW'(IMG_H - 1));
        next_col   = at_end_col ? '0 : cur_col + 1'b1;
        complete   = (cur_col >= CW'(K - 1)) && (cur_row >= RW'(K - 1));
    end

    // Line buffer gi holds row (row - K + 1 + gi); on each accepted pixel the
    // column shifts up one buffer. The read is registered one pixel ahead.
    generate
        for (gi = 0; gi < NLB; gi++) begin : g_lb
            logic [IntSize-1:0] mem [IMG_W];
            logic [IntSize-1:0] rd_reg;
            logic [IntSize-1:0] wr_data;

            if (gi == NLB - 1) begin : g_top
                assign wr_data = pix_in;
            end else begin : g_mid
                assign wr_data = lb_rd[gi + 1];
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[cur_col] <= wr_data;
                    rd_reg       <= mem[next_col];
                end
            end

            assign lb_rd[gi] = rd_reg;
        end

        for (gi = 0; gi < K; gi++) begin : g_col
            if (gi < NLB) begin : g_old
                assign new_col[gi] = lb_rd[gi];
            end else begin : g_new
                assign new_col[gi] = pix_in;
            end
        end

        // Window cell k = r*K + c; columns move left, the new column enters at c = K-1.
        for (gi = 0; gi < K * K; gi++) begin : g_win
            logic [IntSize-1:0] cell_reg;
            logic [IntSize-1:0] cell_next;

            if ((gi % K) == K - 1) begin : g_edge
                assign cell_next = new_col[gi / K];
            end else begin : g_shift
                assign cell_next = win_out[IntSize*(gi+1) +: IntSize];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cell_reg <= '0;
                end else if (accept) begin
                    cell_reg <= cell_next;
                end
            end

            assign win_out[IntSize*gi +: IntSize] = cell_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg       <= '0;
            row_reg       <= '0;
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
        end else begin
            if (win_ready) begin
                win_valid_reg <= 1'b0;
                win_last_reg  <= 1'b0;
            end
            if (accept) begin
                col_reg <= next_col;
                if (at_end_col) begin
                    row_reg <= at_end_row ? '0 : cur_row + 1'b1;
                end else begin
                    row_reg <= cur_row;
                end
                if (complete) begin
                    win_valid_reg <= 1'b1;
                    win_last_reg  <= at_end_col && at_end_row;
                end
            end
        end
    end

`ifdef CONV_WINDOW_GEN_STATUS_EN
    // Counts completed frames: the final window of a frame handing off downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
        end else if (win_valid_reg && win_ready && win_last_reg) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
